// File: rtl/xc_malu_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xc_malu_unit                                                    |
// | Purpose  : Multi-cycle multiply/divide unit for the XCrypto execute stage. |
// |            Divide/remainder, 32x32->64 integer and carryless multiply,     |
// |            packed-lane multiply and multi-precision madd/msub/macc/mmul   |
// |            all run on one bit-serial datapath around a 64-bit accumulator. |
// | Ports    : clock, reset (async, active-high)                               |
// |            rs1/rs2/rs3 [31:0] operands, valid request, flush (on ready)    |
// |            uop_* one-hot op select, mod_* signedness/carryless modifiers   |
// |            pw_* one-hot packed lane width                                  |
// |            result [63:0], accumulator [63:0], n_accumulator [63:0], ready  |
// | Config   : XC_MALU_PMUL_EN - define to build the packed multiply lanes;    |
// |            otherwise uop_pmul finishes in 1 cycle with result 0.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module xc_malu_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] rs3,
  input  logic        flush,
  input  logic        valid,
  input  logic        uop_div,
  input  logic        uop_rem,
  input  logic        uop_mul,
  input  logic        uop_pmul,
  input  logic        uop_madd,
  input  logic        uop_msub_1,
  input  logic        uop_msub_2,
  input  logic        uop_macc_1,
  input  logic        uop_macc_2,
  input  logic        uop_mmul_1,
  input  logic        uop_mmul_2,
  input  logic        mod_lh_sign,
  input  logic        mod_rh_sign,
  input  logic        mod_carryless,
  input  logic        pw_32,
  input  logic        pw_16,
  input  logic        pw_8,
  input  logic        pw_4,
  input  logic        pw_2,
  output logic [63:0] result,
  output logic [63:0] accumulator,
  output logic [63:0] n_accumulator,
  output logic        ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;   // 0..31 iterate, 32 = final fix-up step
  logic [63:0] acc_q, acc_d;
  logic [63:0] result_q, result_d;

  // --------------------------------------------------------------------------
  // Operation classes
  // --------------------------------------------------------------------------
  logic is_divrem, clmul, use_sign, short_op, keep_acc;

  assign is_divrem = uop_div | uop_rem;
  assign clmul     = mod_carryless & (uop_mul | uop_pmul);
  assign use_sign  = is_divrem | (uop_mul & ~mod_carryless);

`ifdef XC_MALU_PMUL_EN
  assign short_op  = uop_msub_2 | uop_macc_2;
  assign keep_acc  = uop_msub_2 | uop_macc_2 | uop_mmul_2;
`else
  // Without the packed lanes, pmul is a one-step no-op that leaves acc alone.
  assign short_op  = uop_msub_2 | uop_macc_2 | uop_pmul;
  assign keep_acc  = uop_msub_2 | uop_macc_2 | uop_mmul_2 | uop_pmul;
`endif

  // pw_32 only marks the default lane width; it carries no extra information.
  logic unused_pw;
  assign unused_pw = ^{pw_32, pw_16, pw_8, pw_4, pw_2};

  // Signed ops work on magnitudes and fix the sign up in the final step.
  logic        neg1, neg2;
  logic [31:0] mag1, mag2;

  assign neg1 = use_sign & mod_lh_sign & rs1[31];
  assign neg2 = use_sign & mod_rh_sign & rs2[31];
  assign mag1 = neg1 ? (~rs1 + 32'd1) : rs1;
  assign mag2 = neg2 ? (~rs2 + 32'd1) : rs2;

  logic [4:0] cnt;
  assign cnt = count_q[4:0];

  // --------------------------------------------------------------------------
  // Multiply step: LSB-first, the multiplicand is shifted into place and added
  // (or XORed) into the accumulator, so a retained accumulator value (mmul_2)
  // is simply the starting point of the sum.
  // --------------------------------------------------------------------------
  logic [63:0] addend;

`ifdef XC_MALU_PMUL_EN
  // Lane products are packed at 2w-bit spacing in the accumulator so no lane
  // can carry into its neighbour; a 32-bit "lane" degenerates to plain mul.
  logic [4:0]  lane_mask, bitpos, lane_base;
  logic [31:0] amask, lane_a;
  logic [5:0]  sh;

  always_comb begin
    lane_mask = 5'd31;
    if (uop_pmul) begin
      if (pw_16)     lane_mask = 5'd15;
      else if (pw_8) lane_mask = 5'd7;
      else if (pw_4) lane_mask = 5'd3;
      else if (pw_2) lane_mask = 5'd1;
    end
  end

  assign bitpos    = cnt & lane_mask;
  assign lane_base = cnt & ~lane_mask;
  assign amask     = 32'hFFFF_FFFF >> (5'd31 - lane_mask);
  assign lane_a    = (mag1 >> lane_base) & amask;
  assign sh        = {lane_base, 1'b0} + {1'b0, bitpos};
  assign addend    = {32'd0, lane_a} << sh;

  // Gather lane i's low half into result[31:0] and high half into [63:32].
  function automatic logic [63:0] f_unpack(input logic [63:0] p, input logic [4:0] lm);
    logic [63:0] r;
    int          off, lb, m;
    logic [5:0]  lo_i, hi_i;
    r = '0;
    m = int'({27'd0, lm});
    for (int k = 0; k < 32; k++) begin
      off       = k & m;
      lb        = k - off;
      lo_i      = 6'(2 * lb + off);
      hi_i      = 6'(2 * lb + off + m + 1);
      r[k]      = p[lo_i];
      r[k + 32] = p[hi_i];
    end
    return r;
  endfunction
`else
  assign addend = {32'd0, mag1} << cnt;
`endif

  logic [63:0] mul_next;
  always_comb begin
    mul_next = acc_q;
    if (mag2[cnt]) mul_next = clmul ? (acc_q ^ addend) : (acc_q + addend);
  end

  // --------------------------------------------------------------------------
  // Restoring divide step: acc = {remainder, dividend/quotient}. The shifted
  // partial remainder needs 33 bits when the divisor exceeds 2^31.
  // --------------------------------------------------------------------------
  logic [63:0] work, div_next;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        ge;

  assign work     = (count_q == 6'd0) ? {32'd0, mag1} : acc_q;
  assign rem_sh   = {work[63:32], work[31]};
  assign diff     = {1'b0, rem_sh} - {2'b00, mag2};
  assign ge       = ~diff[33];
  assign div_next = {(ge ? diff[31:0] : rem_sh[31:0]), work[30:0], ge};

  // --------------------------------------------------------------------------
  // Final fix-up step
  // --------------------------------------------------------------------------
  logic [31:0] q_fix, r_fix;
  logic [63:0] fin_acc, fin_res;

  assign q_fix = (rs2 == 32'd0) ? 32'hFFFF_FFFF :
                 ((neg1 ^ neg2) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
  assign r_fix = neg1 ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    fin_acc = acc_q;
    if (uop_div)         fin_acc = {32'd0, q_fix};
    else if (uop_rem)    fin_acc = {32'd0, r_fix};
    else if (uop_mul)    fin_acc = (neg1 ^ neg2) ? (~acc_q + 64'd1) : acc_q;
    else if (uop_madd)   fin_acc = acc_q + {32'd0, rs3};
    else if (uop_msub_2) fin_acc = acc_q - {32'd0, rs3};
    else if (uop_macc_2) fin_acc = acc_q + {rs2, rs1};
`ifdef XC_MALU_PMUL_EN
    else if (uop_pmul)   fin_acc = f_unpack(acc_q, lane_mask);
`endif
    fin_res = fin_acc;
`ifndef XC_MALU_PMUL_EN
    if (uop_pmul) fin_res = 64'd0;
`endif
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (!valid) begin
      state_d = S_IDLE;
      count_d = 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
          count_d = 6'd0;
          acc_d   = keep_acc ? acc_q : 64'd0;
        end
        S_RUN: begin
          if (short_op || (count_q == 6'd32)) begin
            state_d  = S_DONE;
            acc_d    = fin_acc;
            result_d = fin_res;
          end else begin
            acc_d   = is_divrem ? div_next : mul_next;
            count_d = count_q + 6'd1;
          end
        end
        S_DONE: begin
          if (flush) begin
            state_d = S_IDLE;
            count_d = 6'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= 6'd0;
      acc_q    <= 64'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result        = result_q;
  assign accumulator   = acc_q;
  assign n_accumulator = (state_q == S_RUN) ? acc_d : acc_q;
  assign ready         = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_xc_malu_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_xc_malu_unit                                                 |
// | Purpose  : Directed self-checking bench for xc_malu_unit with a scoreboard |
// |            of expected result/accumulator/latency per operation.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_xc_malu_unit;

  // uop bit order: {div, rem, mul, pmul, madd, msub_1, msub_2, macc_1, macc_2, mmul_1, mmul_2}
  localparam logic [10:0] U_DIV  = 11'b100_0000_0000;
  localparam logic [10:0] U_REM  = 11'b010_0000_0000;
  localparam logic [10:0] U_MUL  = 11'b001_0000_0000;
  localparam logic [10:0] U_PMUL = 11'b000_1000_0000;
  localparam logic [10:0] U_MADD = 11'b000_0100_0000;
  localparam logic [10:0] U_MS1  = 11'b000_0010_0000;
  localparam logic [10:0] U_MS2  = 11'b000_0001_0000;
  localparam logic [10:0] U_MA1  = 11'b000_0000_1000;
  localparam logic [10:0] U_MA2  = 11'b000_0000_0100;
  localparam logic [10:0] U_MM1  = 11'b000_0000_0010;
  localparam logic [10:0] U_MM2  = 11'b000_0000_0001;
  // pw order: {pw_32, pw_16, pw_8, pw_4, pw_2}
  localparam logic [4:0]  PW32   = 5'b10000;
  localparam logic [4:0]  PW16   = 5'b01000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rs1 = '0, rs2 = '0, rs3 = '0;
  logic        flush = 1'b0, valid = 1'b0;
  logic [10:0] uops = '0;
  logic        lh = 1'b0, rh = 1'b0, cl = 1'b0;
  logic [4:0]  pw = PW32;
  logic [63:0] result, accumulator, n_accumulator;
  logic        ready;

  xc_malu_unit dut (
    .clock(clock), .reset(reset),
    .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .flush(flush), .valid(valid),
    .uop_div(uops[10]), .uop_rem(uops[9]), .uop_mul(uops[8]), .uop_pmul(uops[7]),
    .uop_madd(uops[6]), .uop_msub_1(uops[5]), .uop_msub_2(uops[4]),
    .uop_macc_1(uops[3]), .uop_macc_2(uops[2]), .uop_mmul_1(uops[1]), .uop_mmul_2(uops[0]),
    .mod_lh_sign(lh), .mod_rh_sign(rh), .mod_carryless(cl),
    .pw_32(pw[4]), .pw_16(pw[3]), .pw_8(pw[2]), .pw_4(pw[1]), .pw_2(pw[0]),
    .result(result), .accumulator(accumulator), .n_accumulator(n_accumulator),
    .ready(ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic [63:0] acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [10:0] u,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic s1, input logic s2, input logic clm, input logic [4:0] w,
                        input logic [63:0] eres, input logic [63:0] eacc, input int elat);
    exp_t e;
    int   n;
    @(negedge clock);
    rs1 = a; rs2 = b; rs3 = c; uops = u; lh = s1; rh = s2; cl = clm; pw = w;
    valid = 1'b1;
    sb.push_back('{tag: tag, res: eres, acc: eacc, lat: elat});
    @(posedge clock);                       // edge that first samples valid
    n = 0;
    while (n < 100) begin
      @(posedge clock); #1;
      n++;
      if (ready) break;
    end
    e = sb.pop_front();
    chk({e.tag, "_lat"}, 64'(n), 64'(e.lat));
    chk({e.tag, "_res"}, result, e.res);
    chk({e.tag, "_acc"}, accumulator, e.acc);
    chk({e.tag, "_nacc"}, n_accumulator, e.acc);
    @(posedge clock); #1;                   // result must hold while waiting for flush
    chk({e.tag, "_hold"}, result, e.res);
    chk({e.tag, "_rdyhold"}, 64'(ready), 64'd1);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock); #1;
    chk({e.tag, "_flushed"}, 64'(ready), 64'd0);
    @(negedge clock);
    flush = 1'b0; valid = 1'b0; uops = '0;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_result", result, 64'd0);
    chk("rst_acc", accumulator, 64'd0);
    chk("rst_nacc", n_accumulator, 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Integer multiply, all signedness combinations
    run_op("mul_uu", U_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, PW32,
           64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFE_0000_0001, 33);
    run_op("mul_ss", U_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 1, 0, PW32,
           64'd1, 64'd1, 33);
    run_op("mul_su", U_MUL, 32'hFFFF_FFFE, 32'd3, 0, 1, 0, 0, PW32,
           64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFA, 33);
    run_op("mul_us", U_MUL, 32'd5, 32'hFFFF_FFFF, 0, 0, 1, 0, PW32,
           64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 33);
    // Carryless: signs ignored
    run_op("clmul_msb", U_MUL, 32'h8000_0000, 32'h8000_0000, 0, 1, 1, 1, PW32,
           64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 33);
    run_op("clmul_3x3", U_MUL, 32'd3, 32'd3, 0, 0, 0, 1, PW32, 64'd5, 64'd5, 33);

    // Packed multiply (accumulator is 5 from the previous op)
`ifdef XC_MALU_PMUL_EN
    run_op("pmul16", U_PMUL, 32'h0003_0002, 32'h0005_0004, 0, 0, 0, 0, PW16,
           64'h0000_0000_000F_0008, 64'h0000_0000_000F_0008, 33);
`else
    run_op("pmul16", U_PMUL, 32'h0003_0002, 32'h0005_0004, 0, 0, 0, 0, PW16,
           64'd0, 64'd5, 1);
`endif

    // Divide / remainder including the boundary cases
    run_op("div_s", U_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1, 1, 0, PW32,
           64'h0000_0000_FFFF_FFFD, 64'h0000_0000_FFFF_FFFD, 33);
    run_op("rem_s", U_REM, 32'hFFFF_FFF9, 32'd2, 0, 1, 1, 0, PW32,
           64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 33);
    run_op("div_0", U_DIV, 32'd7, 32'd0, 0, 0, 0, 0, PW32,
           64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 33);
    run_op("rem_0", U_REM, 32'd7, 32'd0, 0, 0, 0, 0, PW32, 64'd7, 64'd7, 33);
    run_op("div_ovf", U_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 1, 0, PW32,
           64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 33);
    run_op("rem_ovf", U_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 1, 0, PW32,
           64'd0, 64'd0, 33);
    run_op("divu_big", U_DIV, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0, 0, 0, PW32,
           64'd1, 64'd1, 33);
    run_op("remu_big", U_REM, 32'hFFFF_FFFF, 32'h8000_0001, 0, 0, 0, 0, PW32,
           64'h0000_0000_7FFF_FFFE, 64'h0000_0000_7FFF_FFFE, 33);

    // Multiply-add and two-step multi-precision ops
    run_op("madd", U_MADD, 32'h0001_0000, 32'h0001_0000, 32'd5, 0, 0, 0, PW32,
           64'h0000_0001_0000_0005, 64'h0000_0001_0000_0005, 33);
    run_op("msub1", U_MS1, 32'd3, 32'd4, 0, 0, 0, 0, PW32, 64'd12, 64'd12, 33);
    run_op("msub2", U_MS2, 32'd0, 32'd0, 32'd2, 0, 0, 0, PW32, 64'd10, 64'd10, 1);
    run_op("macc1", U_MA1, 32'd2, 32'd3, 0, 0, 0, 0, PW32, 64'd6, 64'd6, 33);
    run_op("macc2", U_MA2, 32'd0, 32'd1, 0, 0, 0, 0, PW32,
           64'h0000_0001_0000_0006, 64'h0000_0001_0000_0006, 1);
    run_op("mmul1", U_MM1, 32'd3, 32'd4, 0, 0, 0, 0, PW32, 64'd12, 64'd12, 33);
    run_op("mmul2", U_MM2, 32'd2, 32'd5, 0, 0, 0, 0, PW32, 64'd22, 64'd22, 33);

    // Dropping valid mid-operation abandons it: ready never appears
    @(negedge clock);
    rs1 = 32'd9; rs2 = 32'd9; uops = U_MUL; lh = 0; rh = 0; cl = 0; pw = PW32; valid = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    valid = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    chk("abandon_ready", 64'(ready), 64'd0);

    // Reset mid-RUN: partial product 3*4 reaches 12 after bit 2, then clears
    @(negedge clock);
    rs1 = 32'd3; rs2 = 32'd4; uops = U_MM1; valid = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("midrun_partial", accumulator, 64'd12);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrun_rst_acc", accumulator, 64'd0);
    chk("midrun_rst_ready", 64'(ready), 64'd0);
    chk("midrun_rst_result", result, 64'd0);
    @(negedge clock);
    reset = 1'b0; valid = 1'b0; uops = '0;

    // Reset while DONE clears ready at once
    @(negedge clock);
    rs1 = 32'd6; rs2 = 32'd7; uops = U_MUL; valid = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clock); #1;
      n++;
      if (ready) break;
    end
    chk("done_ready", 64'(ready), 64'd1);
    chk("done_result", result, 64'd42);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("done_rst_ready", 64'(ready), 64'd0);
    chk("done_rst_acc", accumulator, 64'd0);
    @(negedge clock);
    reset = 1'b0; valid = 1'b0; uops = '0;
    repeat (2) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
